fft64_out_reorder: RTL and testbench



---
 rtl/fft64_out_pkg.sv | 27 ++
 rtl/fft64_dp_ram.sv | 33 +++
 rtl/fft64_out_reorder.sv | 149 ++++++++++++++
 tb/tb_fft64_out_reorder.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft64_out_pkg.sv
// Shared constants, state encodings and the 6-bit bit-reversal helper
// for the 64-point FFT output reorder buffer.
package fft64_out_pkg;

  localparam int N          = 64;
  localparam int LOGN       = 6;
  localparam int NB_DEFAULT = 16;

  typedef enum logic {
    W_IDLE,
    W_FILL
  } wstate_t;

  typedef enum logic {
    R_IDLE,
    R_DRAIN
  } rstate_t;

  function automatic logic [LOGN-1:0] bitrev6(input logic [LOGN-1:0] x);
    logic [LOGN-1:0] r;
    for (int i = 0; i < LOGN; i++) begin
      r[i] = x[LOGN-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft64_dp_ram.sv
// Two 64-word banks in one 128-deep simple dual-port RAM; the address MSB
// selects the bank. Both ports only act on enabled clocks.
module fft64_dp_ram
  import fft64_out_pkg::*;
#(
  parameter int WIDTH = 2 * (NB_DEFAULT + 2)
) (
  input  logic             clk,
  input  logic             ed,
  input  logic             we,
  input  logic [LOGN:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [LOGN:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [0:2*N-1];

  always_ff @(posedge clk) begin
    if (ed && we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read data is left unreset; the top only consumes it behind a valid flag.
  always_ff @(posedge clk) begin
    if (ed && re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/fft64_out_reorder.sv
// Ping-pong reorder buffer: bit-reversed-order input frames are written at
// bit-reversed addresses and read back in natural order, one sample per ED.
module fft64_out_reorder
  import fft64_out_pkg::*;
#(
  parameter int nb = NB_DEFAULT
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  input  logic                 ED,
  input  logic                 START,
  input  logic signed [nb+1:0] DR,
  input  logic signed [nb+1:0] DI,
  input  logic                 OVFI,
  output logic                 RDY,
  output logic signed [nb+1:0] DOR,
  output logic signed [nb+1:0] DOI,
  output logic [LOGN-1:0]      ADDR,
  output logic                 OVF
);

  localparam int SW = nb + 2;
  localparam int WW = 2 * SW;

  wstate_t         wstate;
  logic [LOGN-1:0] wcnt;
  logic            wbank;
  logic            wovf;

  rstate_t         rstate;
  logic [LOGN-1:0] rcnt;
  logic            rbank;
  logic            rovf;

  logic            rd_valid;
  logic [LOGN-1:0] rd_idx;
  logic            rd_ovf;

  logic            we;
  logic            re;
  logic [LOGN-1:0] wptr;
  logic [LOGN:0]   waddr;
  logic [LOGN:0]   raddr;
  logic [WW-1:0]   wdata;
  logic [WW-1:0]   rdata;
  logic            handoff;

  // START always writes sample 0, so an aborted frame restarts at address 0.
  always_comb begin
    wptr    = START ? '0 : wcnt;
    we      = START || (wstate == W_FILL);
    waddr   = {wbank, bitrev6(wptr)};
    wdata   = {DR, DI};
    re      = (rstate == R_DRAIN);
    raddr   = {rbank, rcnt};
    handoff = ED && !START && (wstate == W_FILL) && (wcnt == LOGN'(N - 1));
  end

  fft64_dp_ram #(
    .WIDTH(WW)
  ) u_ram (
    .clk  (CLK),
    .ed   (ED),
    .we   (we),
    .waddr(waddr),
    .wdata(wdata),
    .re   (re),
    .raddr(raddr),
    .rdata(rdata)
  );

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      wstate <= W_IDLE;
      wcnt   <= '0;
      wbank  <= 1'b0;
      wovf   <= 1'b0;
    end else if (ED) begin
      if (START) begin
        wstate <= W_FILL;
        wcnt   <= LOGN'(1);
        wovf   <= OVFI;
      end else if (wstate == W_FILL) begin
        wovf <= wovf | OVFI;
        wcnt <= wcnt + 1'b1;
        if (wcnt == LOGN'(N - 1)) begin
          wstate <= W_IDLE;
          wbank  <= ~wbank;
        end
      end
    end
  end

  // A handoff on the rcnt=63 read restarts the drain with no idle cycle.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      rstate <= R_IDLE;
      rcnt   <= '0;
      rbank  <= 1'b0;
      rovf   <= 1'b0;
    end else if (ED) begin
      if (handoff) begin
        rstate <= R_DRAIN;
        rcnt   <= '0;
        rbank  <= wbank;
        rovf   <= wovf | OVFI;
      end else if (rstate == R_DRAIN) begin
        rcnt <= rcnt + 1'b1;
        if (rcnt == LOGN'(N - 1)) begin
          rstate <= R_IDLE;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      rd_valid <= 1'b0;
      rd_idx   <= '0;
      rd_ovf   <= 1'b0;
    end else if (ED) begin
      rd_valid <= (rstate == R_DRAIN);
      rd_idx   <= rcnt;
      rd_ovf   <= rovf;
    end
  end

  // OVF only moves on the index-0 word so it stays constant across a frame.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      RDY  <= 1'b0;
      DOR  <= '0;
      DOI  <= '0;
      ADDR <= '0;
      OVF  <= 1'b0;
    end else if (ED) begin
      RDY <= rd_valid && (rd_idx == '0);
      if (rd_valid) begin
        DOR  <= rdata[WW-1:SW];
        DOI  <= rdata[SW-1:0];
        ADDR <= rd_idx;
        if (rd_idx == '0) begin
          OVF <= rd_ovf;
        end
      end
    end
  end

endmodule

// File: tb/tb_fft64_out_reorder.sv
// Directed self-checking bench for fft64_out_reorder; edge e counts enabled
// clock edges from the START edge of the scenario.
module tb_fft64_out_reorder;

  localparam int NB = 16;
  localparam int W  = NB + 2;

  logic                clk   = 1'b0;
  logic                rst_n = 1'b0;
  logic                ed    = 1'b0;
  logic                start = 1'b0;
  logic signed [W-1:0] dr    = '0;
  logic signed [W-1:0] di    = '0;
  logic                ovfi  = 1'b0;
  logic                rdy;
  logic signed [W-1:0] dor;
  logic signed [W-1:0] doi;
  logic [5:0]          addr;
  logic                ovf;

  int checks = 0;
  int errors = 0;

  fft64_out_reorder #(.nb(NB)) dut (
    .CLK  (clk),
    .RSTn (rst_n),
    .ED   (ed),
    .START(start),
    .DR   (dr),
    .DI   (di),
    .OVFI (ovfi),
    .RDY  (rdy),
    .DOR  (dor),
    .DOI  (doi),
    .ADDR (addr),
    .OVF  (ovf)
  );

  always #5 clk = ~clk;

  function automatic int rev6(input int x);
    int r;
    r = 0;
    for (int i = 0; i < 6; i++) begin
      r = r | (((x >> i) & 1) << (5 - i));
    end
    return r;
  endfunction

  // Drives one cycle of inputs, then returns 1 time unit after the edge.
  task automatic apply_stimulus(input logic e, input logic s, input int r, input int i, input logic o);
    ed    = e;
    start = s;
    dr    = W'(r);
    di    = W'(i);
    ovfi  = o;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (rdy !== 1'b0) begin errors++; $display("[TB] FAIL reset_rdy: got %0b, expected 0", rdy); end
    checks++; if (dor !== '0) begin errors++; $display("[TB] FAIL reset_dor: got %0d, expected 0", dor); end
    checks++; if (doi !== '0) begin errors++; $display("[TB] FAIL reset_doi: got %0d, expected 0", doi); end
    checks++; if (addr !== 6'd0) begin errors++; $display("[TB] FAIL reset_addr: got %0d, expected 0", addr); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf: got %0b, expected 0", ovf); end
    rst_n = 1'b1;
    // Data without a START must be ignored.
    for (int e = 0; e < 4; e++) begin
      apply_stimulus(1'b1, 1'b0, 55, 55, 1'b1);
      checks++; if (rdy !== 1'b0) begin errors++; $display("[TB] FAIL idle_rdy: got %0b, expected 0", rdy); end
    end
  endtask

  task automatic test_impulse;
    int j, ex;
    for (int e = 0; e < 131; e++) begin
      if (e < 64) apply_stimulus(1'b1, e == 0, (e == 1) ? 100 : 0, 0, 1'b0);
      else        apply_stimulus(1'b1, 1'b0, 0, 0, 1'b0);
      j  = (e >= 65 && e <= 128) ? e - 65 : 63;
      ex = (j == 32) ? 100 : 0;
      if (e < 65) begin
        checks++; if (rdy !== 1'b0) begin errors++; $display("[TB] FAIL impulse_early_rdy e=%0d: got %0b, expected 0", e, rdy); end
      end else begin
        checks++; if (rdy !== (e == 65)) begin errors++; $display("[TB] FAIL impulse_rdy e=%0d: got %0b, expected %0b", e, rdy, e == 65); end
        checks++; if (addr !== 6'(j)) begin errors++; $display("[TB] FAIL impulse_addr e=%0d: got %0d, expected %0d", e, addr, j); end
        checks++; if (dor !== W'(ex)) begin errors++; $display("[TB] FAIL impulse_dor e=%0d: got %0d, expected %0d", e, dor, ex); end
        checks++; if (doi !== '0) begin errors++; $display("[TB] FAIL impulse_doi e=%0d: got %0d, expected 0", e, doi); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL impulse_ovf e=%0d: got %0b, expected 0", e, ovf); end
      end
    end
  endtask

  task automatic test_ramp;
    int j, ex;
    for (int e = 0; e < 130; e++) begin
      if (e < 64) apply_stimulus(1'b1, e == 0, e, -e, 1'b0);
      else        apply_stimulus(1'b1, 1'b0, 0, 0, 1'b0);
      if (e >= 65) begin
        j  = (e <= 128) ? e - 65 : 63;
        ex = rev6(j);
        checks++; if (rdy !== (e == 65)) begin errors++; $display("[TB] FAIL ramp_rdy e=%0d: got %0b, expected %0b", e, rdy, e == 65); end
        checks++; if (addr !== 6'(j)) begin errors++; $display("[TB] FAIL ramp_addr e=%0d: got %0d, expected %0d", e, addr, j); end
        checks++; if (dor !== W'(ex)) begin errors++; $display("[TB] FAIL ramp_dor e=%0d: got %0d, expected %0d", e, dor, ex); end
        checks++; if (doi !== W'(-ex)) begin errors++; $display("[TB] FAIL ramp_doi e=%0d: got %0d, expected %0d", e, doi, -ex); end
      end
    end
  endtask

  task automatic test_back_to_back;
    int o, f, j, x, ex;
    for (int e = 0; e < 259; e++) begin
      if (e < 192) begin
        f = e / 64;
        x = f * 256 + e % 64;
        apply_stimulus(1'b1, (e % 64) == 0, x, -x - 1, 1'b0);
      end else begin
        apply_stimulus(1'b1, 1'b0, 0, 0, 1'b0);
      end
      o = e - 65;
      if (o >= 0 && o < 192) begin
        f  = o / 64;
        j  = o % 64;
        ex = f * 256 + rev6(j);
        checks++; if (rdy !== (j == 0)) begin errors++; $display("[TB] FAIL b2b_rdy e=%0d: got %0b, expected %0b", e, rdy, j == 0); end
        checks++; if (addr !== 6'(j)) begin errors++; $display("[TB] FAIL b2b_addr e=%0d: got %0d, expected %0d", e, addr, j); end
        checks++; if (dor !== W'(ex)) begin errors++; $display("[TB] FAIL b2b_dor e=%0d: got %0d, expected %0d", e, dor, ex); end
        checks++; if (doi !== W'(-ex - 1)) begin errors++; $display("[TB] FAIL b2b_doi e=%0d: got %0d, expected %0d", e, doi, -ex - 1); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL b2b_ovf e=%0d: got %0b, expected 0", e, ovf); end
      end else begin
        checks++; if (rdy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_idle_rdy e=%0d: got %0b, expected 0", e, rdy); end
      end
    end
  endtask

  // ED drops every third clock; outputs must freeze on those clocks.
  task automatic test_ed_gaps;
    int   e, c, o, f, j, x;
    logic ex_valid, ex_rdy;
    int   ex_addr, ex_dor;
    e = 0; c = 0;
    ex_valid = 1'b0; ex_rdy = 1'b0; ex_addr = 0; ex_dor = 0;
    while (e < 196) begin
      if ((c % 3) != 2) begin
        if (e < 128) begin
          f = e / 64;
          x = f * 256 + e % 64;
          apply_stimulus(1'b1, (e % 64) == 0, x, -x - 1, 1'b0);
        end else begin
          apply_stimulus(1'b1, 1'b0, 0, 0, 1'b0);
        end
        o = e - 65;
        if (o >= 0 && o < 128) begin
          f = o / 64;
          j = o % 64;
          ex_valid = 1'b1;
          ex_rdy   = (j == 0);
          ex_addr  = j;
          ex_dor   = f * 256 + rev6(j);
        end else if (o >= 128) begin
          ex_rdy = 1'b0;
        end
        e++;
      end else begin
        apply_stimulus(1'b0, 1'b0, 12345, -999, 1'b1);
      end
      c++;
      checks++; if (rdy !== ex_rdy) begin errors++; $display("[TB] FAIL gap_rdy c=%0d: got %0b, expected %0b", c, rdy, ex_rdy); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL gap_ovf c=%0d: got %0b, expected 0", c, ovf); end
      if (ex_valid) begin
        checks++; if (addr !== 6'(ex_addr)) begin errors++; $display("[TB] FAIL gap_addr c=%0d: got %0d, expected %0d", c, addr, ex_addr); end
        checks++; if (dor !== W'(ex_dor)) begin errors++; $display("[TB] FAIL gap_dor c=%0d: got %0d, expected %0d", c, dor, ex_dor); end
        checks++; if (doi !== W'(-ex_dor - 1)) begin errors++; $display("[TB] FAIL gap_doi c=%0d: got %0d, expected %0d", c, doi, -ex_dor - 1); end
      end
    end
  endtask

  // Frame A flags overflow at sample 40, B is clean, C is restarted at sample 20.
  task automatic test_overflow_abort;
    int   j, ex, ex_i;
    logic ex_rdy, ex_ovf;
    for (int e = 0; e < 279; e++) begin
      if (e < 64)       apply_stimulus(1'b1, e == 0, 1000 + e, 0, e == 40);
      else if (e < 128) apply_stimulus(1'b1, e == 64, 2000 + e - 64, 0, 1'b0);
      else if (e < 148) apply_stimulus(1'b1, e == 128, 7777, 7777, e == 135);
      else if (e < 212) apply_stimulus(1'b1, e == 148, 3000 + e - 148, -(e - 148), 1'b0);
      else              apply_stimulus(1'b1, 1'b0, 0, 0, 1'b0);
      ex_ovf = 1'b0;
      ex_i   = 0;
      if (e >= 65 && e < 129) begin
        j = e - 65;  ex = 1000 + rev6(j); ex_ovf = 1'b1;
      end else if (e >= 129 && e < 193) begin
        j = e - 129; ex = 2000 + rev6(j);
      end else if (e >= 193 && e < 213) begin
        j = 63;      ex = 2000 + rev6(63);
      end else if (e >= 213 && e < 277) begin
        j = e - 213; ex = 3000 + rev6(j); ex_i = -rev6(j);
      end else begin
        j = 63;      ex = 3000 + rev6(63); ex_i = -rev6(63);
      end
      ex_rdy = (e == 65) || (e == 129) || (e == 213);
      checks++; if (rdy !== ex_rdy) begin errors++; $display("[TB] FAIL ovab_rdy e=%0d: got %0b, expected %0b", e, rdy, ex_rdy); end
      if (e >= 65) begin
        checks++; if (addr !== 6'(j)) begin errors++; $display("[TB] FAIL ovab_addr e=%0d: got %0d, expected %0d", e, addr, j); end
        checks++; if (dor !== W'(ex)) begin errors++; $display("[TB] FAIL ovab_dor e=%0d: got %0d, expected %0d", e, dor, ex); end
        checks++; if (doi !== W'(ex_i)) begin errors++; $display("[TB] FAIL ovab_doi e=%0d: got %0d, expected %0d", e, doi, ex_i); end
        checks++; if (ovf !== ex_ovf) begin errors++; $display("[TB] FAIL ovab_ovf e=%0d: got %0b, expected %0b", e, ovf, ex_ovf); end
      end
    end
  endtask

  task automatic test_reset_mid_drain;
    for (int e = 0; e < 96; e++) begin
      if (e < 64) apply_stimulus(1'b1, e == 0, 500 + e, e, e == 0);
      else        apply_stimulus(1'b1, 1'b0, 0, 0, 1'b0);
    end
    checks++; if (addr !== 6'd30) begin errors++; $display("[TB] FAIL mid_addr: got %0d, expected 30", addr); end
    checks++; if (dor !== W'(500 + rev6(30))) begin errors++; $display("[TB] FAIL mid_dor: got %0d, expected %0d", dor, 500 + rev6(30)); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("[TB] FAIL mid_ovf: got %0b, expected 1", ovf); end
    rst_n = 1'b0;
    #1;
    checks++; if (rdy !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_rdy: got %0b, expected 0", rdy); end
    checks++; if (dor !== '0) begin errors++; $display("[TB] FAIL mid_rst_dor: got %0d, expected 0", dor); end
    checks++; if (doi !== '0) begin errors++; $display("[TB] FAIL mid_rst_doi: got %0d, expected 0", doi); end
    checks++; if (addr !== 6'd0) begin errors++; $display("[TB] FAIL mid_rst_addr: got %0d, expected 0", addr); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_ovf: got %0b, expected 0", ovf); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int e = 0; e < 70; e++) begin
      apply_stimulus(1'b1, 1'b0, 0, 0, 1'b0);
      checks++; if ({rdy, addr} !== 7'd0) begin errors++; $display("[TB] FAIL post_rst_quiet e=%0d: got rdy=%0b addr=%0d, expected 0/0", e, rdy, addr); end
    end
    for (int e = 0; e < 67; e++) begin
      if (e < 64) apply_stimulus(1'b1, e == 0, 600 + e, 0, 1'b0);
      else        apply_stimulus(1'b1, 1'b0, 0, 0, 1'b0);
      if (e < 65) begin
        checks++; if (rdy !== 1'b0) begin errors++; $display("[TB] FAIL post_rst_early_rdy e=%0d: got %0b, expected 0", e, rdy); end
      end else begin
        checks++; if (rdy !== (e == 65)) begin errors++; $display("[TB] FAIL post_rst_rdy e=%0d: got %0b, expected %0b", e, rdy, e == 65); end
        checks++; if (addr !== 6'(e - 65)) begin errors++; $display("[TB] FAIL post_rst_addr e=%0d: got %0d, expected %0d", e, addr, e - 65); end
        checks++; if (dor !== W'(600 + rev6(e - 65))) begin errors++; $display("[TB] FAIL post_rst_dor e=%0d: got %0d, expected %0d", e, dor, 600 + rev6(e - 65)); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL post_rst_ovf e=%0d: got %0b, expected 0", e, ovf); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_ramp();
    test_back_to_back();
    test_ed_gaps();
    test_overflow_abort();
    test_reset_mid_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
